lwr_stream_cipher: RTL and testbench

Streaming, parametrised successor to the combinational mod-P encrypt/decrypt pair. Joins a plaintext/ciphertext beat stream with a PRF keystream stream and emits (x ± k) mod P per lane through a registered, valid/ready-handshaked output stage. It supports arbitrary (non-power-of-two) P, multiple lanes per beat and per-beat encrypt/decrypt mode selection. It also tracks the PRF index for the upstream PRF core. It sits between the LWR-PRF core and the message buffer.

---
 rtl/lwr_stream_cipher.sv | 109 ++++++++++
 tb/tb_lwr_stream_cipher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwr_stream_cipher.sv
// rtl/lwr_stream_cipher.sv - per-lane mod-P stream encrypt/decrypt joining data and PRF keystream beats
module lwr_stream_cipher #(
  parameter int P     = 32,
  parameter int LANES = 4,
  parameter int IDX_W = 16,
  localparam int WIDTH = $clog2(P)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_mode,
  input  logic                   in_last,
  input  logic                   prf_valid,
  output logic                   prf_ready,
  input  logic [LANES*WIDTH-1:0] prf_data,
  output logic [IDX_W-1:0]       prf_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic [LANES-1:0]       out_err,
  output logic                   err_sticky,
  output logic                   busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  // P widened by one bit so x + k and x + P - k never overflow
  localparam logic [WIDTH:0] P_EXT = (WIDTH + 1)'(P);

  state_t                 state;
  logic                   slot_free;
  logic                   fire;
  logic [LANES*WIDTH-1:0] next_data;
  logic [LANES-1:0]       next_err;

  // A beat moves only when both streams offer one and the output slot is empty or draining
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && prf_valid && slot_free;
  assign prf_ready = !rst && in_valid && slot_free;
  assign fire      = in_valid && in_ready;

  // Per-lane modular add/subtract with out-of-range operands forced to zero and flagged
  always_comb begin
    next_data = '0;
    next_err  = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [WIDTH:0] x;
      logic [WIDTH:0] k;
      logic [WIDTH:0] s;
      logic [WIDTH:0] res;
      x   = {1'b0, in_data[i*WIDTH +: WIDTH]};
      k   = {1'b0, prf_data[i*WIDTH +: WIDTH]};
      s   = x + k;
      res = '0;
      if (x >= P_EXT || k >= P_EXT) begin
        next_err[i] = 1'b1;
      end else if (!in_mode) begin
        res = (s >= P_EXT) ? (s - P_EXT) : s;
      end else begin
        res = (x >= k) ? (x - k) : (x + P_EXT - k);
      end
      next_data[i*WIDTH +: WIDTH] = res[WIDTH-1:0];
    end
  end

  // Output register, message state, PRF index and sticky error; all advance only on fire
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_err    <= '0;
      err_sticky <= 1'b0;
      prf_index  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
      out_last  <= in_last;
      out_err   <= next_err;
      if (|next_err) begin
        err_sticky <= 1'b1;
      end
      // a last beat restarts the keystream index for the next message
      prf_index <= in_last ? '0 : (prf_index + IDX_W'(1));
      case (state)
        IDLE: begin
          state <= in_last ? IDLE : ACTIVE;
          busy  <= !in_last;
        end
        ACTIVE: begin
          state <= in_last ? IDLE : ACTIVE;
          busy  <= !in_last;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lwr_stream_cipher.sv
// tb/tb_lwr_stream_cipher.sv - randomized scoreboard bench for lwr_stream_cipher
module tb_lwr_stream_cipher;
  localparam int P     = 23;
  localparam int LANES = 4;
  localparam int IDX_W = 16;
  localparam int W     = 5;
  localparam int DW    = LANES * W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             in_mode = 1'b0;
  logic             in_last = 1'b0;
  logic             prf_valid = 1'b0;
  logic             prf_ready;
  logic [DW-1:0]    prf_data = '0;
  logic [IDX_W-1:0] prf_index;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [LANES-1:0] out_err;
  logic             err_sticky;
  logic             busy;

  typedef struct {
    logic [DW-1:0]    data;
    logic             last;
    logic [LANES-1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_idx    = 0;
  bit   m_busy   = 0;
  bit   m_sticky = 0;
  bit   m_outv   = 0;

  lwr_stream_cipher #(.P(P), .LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .prf_valid(prf_valid), .prf_ready(prf_ready), .prf_data(prf_data),
    .prf_index(prf_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .err_sticky(err_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(int a0, int a1, int a2, int a3);
    logic [W-1:0] s0, s1, s2, s3;
    s0 = W'(a0); s1 = W'(a1); s2 = W'(a2); s3 = W'(a3);
    return {s3, s2, s1, s0};
  endfunction

  // Reference: ordinary integer modular arithmetic on each symbol
  function automatic exp_t model(logic [DW-1:0] xd, logic [DW-1:0] kd, logic mode, logic last);
    exp_t e;
    e.data = '0;
    e.err  = '0;
    e.last = last;
    for (int i = 0; i < LANES; i++) begin
      int x, k, r;
      x = int'(xd[i*W +: W]);
      k = int'(kd[i*W +: W]);
      if (x >= P || k >= P) begin
        e.err[i] = 1'b1;
        r = 0;
      end else if (!mode) begin
        r = (x + k) % P;
      end else begin
        r = (x - k + P) % P;
      end
      e.data[i*W +: W] = W'(r);
    end
    return e;
  endfunction

  function automatic int rand_sym();
    if ($urandom_range(9) == 0) return 23 + $urandom_range(8);
    return $urandom_range(22);
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return pack(rand_sym(), rand_sym(), rand_sym(), rand_sym());
  endfunction

  // One clock of stimulus plus the per-cycle control-path checks
  task automatic cyc(input logic iv, input logic pv, input logic ordy,
                     input logic [DW-1:0] xd, input logic [DW-1:0] kd,
                     input logic mode, input logic last, output logic dut_fire);
    logic slot;
    logic fired;
    exp_t e;
    @(negedge clk);
    in_valid = iv; prf_valid = pv; out_ready = ordy;
    in_data = xd; prf_data = kd; in_mode = mode; in_last = last;
    #4;
    slot = !m_outv || ordy;
    chk("out_valid", out_valid, m_outv);
    chk("in_ready", in_ready, pv && slot);
    chk("prf_ready", prf_ready, iv && slot);
    chk("prf_index", prf_index, m_idx);
    chk("busy", busy, m_busy);
    chk("err_sticky", err_sticky, m_sticky);
    dut_fire = iv && in_ready;
    fired = iv && pv && slot;
    if (fired) begin
      e = model(xd, kd, mode, last);
      exp_q.push_back(e);
      m_idx    = last ? 0 : ((m_idx + 1) % (1 << IDX_W));
      m_busy   = !last;
      m_sticky = m_sticky || (|e.err);
      m_outv   = 1;
    end else if (ordy) begin
      m_outv = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] xd, input logic [DW-1:0] kd,
                      input logic mode, input logic last, input bit rnd);
    logic f;
    logic iv, pv, ordy;
    int   tries;
    tries = 0;
    f = 0;
    while (!f && tries < 100) begin
      iv   = rnd ? ($urandom_range(3) != 0) : 1'b1;
      pv   = rnd ? ($urandom_range(3) != 0) : 1'b1;
      ordy = rnd ? ($urandom_range(3) != 0) : 1'b1;
      cyc(iv, pv, ordy, xd, kd, mode, last, f);
      f = f && iv && pv;
      tries++;
    end
    if (!f) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) cyc(0, 0, 1, '0, '0, 0, 0, f);
  endtask

  task automatic do_reset(input logic iv, input logic pv);
    @(negedge clk);
    rst = 1; in_valid = iv; prf_valid = pv; out_ready = 0;
    #4;
    chk("in_ready_in_rst", in_ready, 0);
    chk("prf_ready_in_rst", prf_ready, 0);
    @(negedge clk);
    rst = 0; in_valid = 0; prf_valid = 0;
    exp_q.delete();
    m_idx = 0; m_busy = 0; m_sticky = 0; m_outv = 0;
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_prf_index", prf_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_sticky", err_sticky, 0);
  endtask

  // Monitor: pops an expectation for every beat taken downstream and checks stall stability
  initial begin
    bit               stall;
    logic [DW-1:0]    h_data;
    logic             h_last;
    logic [LANES-1:0] h_err;
    exp_t             e;
    stall = 0;
    h_data = '0; h_last = 0; h_err = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("stall_data", out_data, h_data);
          chk("stall_last", out_last, h_last);
          chk("stall_err", out_err, h_err);
        end
        if (out_valid && out_ready) begin
          stall = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", out_last, e.last);
            chk("out_err", out_err, e.err);
          end
        end else if (out_valid) begin
          stall = 1;
          h_data = out_data; h_last = out_last; h_err = out_err;
        end else begin
          stall = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int   cnt;
    logic [DW-1:0] ka;

    do_reset(0, 0);

    // Directed lane vectors, then the out-of-range beat that raises the sticky flag
    ka = pack(1, 22, 12, 3);
    send(pack(22, 0, 11, 5), ka, 0, 0, 0);
    send(pack(0, 22, 0, 8), ka, 1, 0, 0);
    send(pack(4, 7, 30, 9), pack(2, 20, 5, 23), 0, 1, 0);
    idle(3);

    // Backpressure: three cycles of out_ready low take exactly one beat
    cnt = 0;
    cyc(1, 1, 0, pack(1, 2, 3, 4), pack(5, 6, 7, 8), 0, 0, f);
    cnt += int'(f);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, pack(9, 10, 11, 12), pack(13, 14, 15, 16), 1, 0, f);
      cnt += int'(f);
    end
    chk("bp_beats_taken", cnt, 1);
    cnt = 0;
    cyc(1, 1, 1, pack(9, 10, 11, 12), pack(13, 14, 15, 16), 1, 0, f);
    cnt += int'(f);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, rand_beat(), rand_beat(), 1'($urandom_range(1)), 1'(i == 3), f);
      cnt += int'(f);
    end
    chk("release_beats_taken", cnt, 5);
    idle(2);

    // Three-beat message with a two-cycle keystream gap in the middle
    send(rand_beat(), rand_beat(), 0, 0, 0);
    cyc(1, 0, 1, rand_beat(), rand_beat(), 0, 0, f);
    chk("gap_no_fire_0", f, 0);
    cyc(1, 0, 1, rand_beat(), rand_beat(), 0, 0, f);
    chk("gap_no_fire_1", f, 0);
    send(rand_beat(), rand_beat(), 1, 0, 0);
    send(rand_beat(), rand_beat(), 0, 1, 0);
    idle(2);

    // Reset with a pending beat mid-message
    send(rand_beat(), rand_beat(), 0, 0, 0);
    cyc(0, 0, 0, '0, '0, 0, 0, f);
    do_reset(1, 1);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      send(rand_beat(), rand_beat(), 1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1);
    end

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      idle(1);
      cnt++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
